serial_parity_tx: RTL
=====================

Name: serial_parity_tx

Overview:
Transmit-side counterpart of the serial parity detector: it accepts a parallel word over a valid/ready handshake, shifts it out one bit per clock (LSB first) on a serial line, and appends one parity bit. A detector cleared at frame start and fed the DATA_W+1 bits sees the configured parity at the end of the frame. The block is the stimulus source for detector links and the serializer in loopback test paths.

Parameters:
DATA_W, 8, payload width in bits (legal range 2..32)
PARITY_ODD, 0, 0 = even parity (total ones in data+parity is even); 1 = odd parity

Ports:
clock  input  1  single clock; all state changes on posedge
reset_n  input  1  asynchronous, active-low reset
data_in  input  DATA_W  word to transmit; sampled only on an accepted load
load_valid  input  1  data_in is valid this cycle
load_ready  output  1  block can accept a word this cycle
x  output  1  serial data out, LSB first, then the parity bit
x_valid  output  1  x carries a frame bit this cycle
x_last  output  1  high only while x is the parity bit
busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- States: IDLE, DATA, PARITY; the state, shift register, bit counter (clog2(DATA_W) bits) and parity accumulator are all registers.
- Reset (reset_n low, async): state=IDLE, shift reg=0, count=0, parity accumulator=PARITY_ODD. Outputs: x=0, x_valid=0, x_last=0, busy=0, load_ready=1. Takes effect immediately, without waiting for a clock edge.
- Accept: a load is accepted at a posedge where load_valid && load_ready. load_ready=1 in IDLE and in PARITY, and 0 in DATA. load_valid while load_ready=0 is ignored and nothing is queued.
- On accept: shift reg<=data_in, count<=0, parity accumulator<=PARITY_ODD, state<=DATA.
- DATA: x=shreg[0], x_valid=1, x_last=0. Each edge: parity<=parity^shreg[0], shreg shifts right with 0 fill, count++. At the edge where count==DATA_W-1: state<=PARITY.
- PARITY: x=parity accumulator, x_valid=1, x_last=1. At the next edge: state<=DATA if a load is accepted (back-to-back, no gap); otherwise state<=IDLE.
- IDLE: x=0, x_valid=0, x_last=0.
- Latency: first data bit appears on x in the cycle after the accept edge. A frame is exactly DATA_W+1 valid cycles.
- Throughput: one frame every DATA_W+1 cycles when load_valid is held high.
- Parity rule: the parity bit equals XOR of the data bits, XOR PARITY_ODD.
- x, x_valid, x_last and load_ready are decoded from registered state only; they have no combinational path from inputs.
- Reset mid-frame: the frame is aborted with no partial parity bit emitted, and the frame is not resumed after reset.
- data_in may change freely after the accept edge; it does not affect the frame in flight.

Decomposition:
- Shared package serial_parity_pkg:
  - state enum (IDLE/DATA/PARITY)
  - constants PARITY_EVEN=0 and PARITY_ODD=1
  - default DATA_W
  - The package is shared with the detector bench.
- No sub-module is warranted: the shift register, counter and parity accumulator stay inline in one module.

Test Plan:
- Reset, then data_in=8'hB5 with load_valid for 1 cycle, even parity -> x = 1,0,1,0,1,1,0,1 then parity 1 with x_last=1. x_valid is high for 9 cycles, then the block returns to IDLE with load_ready=1.
- data_in=8'h00 with PARITY_ODD=0 -> eight 0s, then parity 0. Same input with PARITY_ODD=1 -> parity 1.
- load_valid held high with 8'hB5 then 8'h3C -> 18 consecutive x_valid cycles. The second frame's bit0 (0) follows the parity bit of the first (1) with no gap. Second parity bit = 0. load_ready pulses only in the PARITY cycles.
- load_valid asserted with 8'hFF during DATA cycles 2-5 of a frame -> ignored. The current frame completes unchanged and no extra frame is sent.
- reset_n pulsed low for 3 ns mid-frame (after bit 3) -> x_valid, x_last and busy drop asynchronously. After release the state is IDLE with no parity bit emitted. The next load of 8'h01 yields 1,0,0,0,0,0,0,0 then parity 1.
- Loopback: feed x into a serial parity detector cleared at each frame start, with random words -> detector output after the parity bit = PARITY_ODD for every frame.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: definitions shared by the serial parity transmitter and
// the serial parity detector bench.
//   tx_state_e  - transmitter frame state (IDLE / DATA / PARITY)
//   PARITY_EVEN - parity selector value: total ones in data+parity is even
//   PARITY_ODD  - parity selector value: total ones in data+parity is odd
//   DEF_DATA_W  - default payload width
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } tx_state_e;

  localparam bit          PARITY_EVEN = 1'b0;
  localparam bit          PARITY_ODD  = 1'b1;
  localparam int unsigned DEF_DATA_W  = 8;

endpackage

// File: rtl/serial_parity_tx.sv
// serial_parity_tx: accepts a parallel word over a valid/ready handshake and
// sends it LSB first on a serial line, followed by one parity bit.
//   clock      - single clock, all state changes on posedge
//   reset_n    - asynchronous active-low reset
//   data_in    - word to transmit, sampled only on an accepted load
//   load_valid - data_in is valid this cycle
//   load_ready - a word can be accepted this cycle (IDLE or PARITY)
//   x          - serial data, LSB first, then the parity bit
//   x_valid    - x carries a frame bit this cycle
//   x_last     - x is the parity bit
//   busy       - a frame is in progress
module serial_parity_tx #(
  parameter int unsigned DATA_W     = serial_parity_pkg::DEF_DATA_W,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              x,
  output logic              x_valid,
  output logic              x_last,
  output logic              busy
);

  import serial_parity_pkg::*;

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              par;
  logic              accept;

  // Outputs decode from registered state only; load_valid only steers the
  // next state, so there is no input-to-output path.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b1;
    x          = 1'b0;
    x_valid    = 1'b0;
    x_last     = 1'b0;
    case (state)
      IDLE: begin
      end
      DATA: begin
        load_ready = 1'b0;
        x          = shreg[0];
        x_valid    = 1'b1;
        if (cnt == CNT_LAST) state_nxt = PARITY;
      end
      PARITY: begin
        x         = par;
        x_valid   = 1'b1;
        x_last    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = load_valid && load_ready;
    // An accept in PARITY chains straight into the next frame with no gap.
    if (accept) state_nxt = DATA;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
      par   <= PARITY_ODD;
    end else if (accept) begin
      shreg <= data_in;
      cnt   <= '0;
      par   <= PARITY_ODD;
    end else if (state == DATA) begin
      par   <= par ^ shreg[0];
      shreg <= {1'b0, shreg[DATA_W-1:1]};
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule
